// File: rtl/pwconv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwconv_pkg
//  Description : Shared types, default geometry and requantiser helper for the
//                pointwise (1x1) convolution engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwconv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC   = 3'd1,
        FLUSH = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Geometry of the default configuration (CHOUT=64, DSP_NO=32, CHIN=256, NPIX=1024).
    localparam int GROUPS = 2;
    localparam int CH_W   = 8;
    localparam int GRP_W  = 1;
    localparam int PIX_W  = 10;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [63:0] sat_shift(
        input logic signed [127:0] acc,
        input int                  frac,
        input int                  width,
        input logic                relu_en
    );
        logic signed [127:0] v;
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        v  = acc >>> frac;
        hi = (128'sd1 <<< (width - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (width - 1));
        if (v > hi) begin
            v = hi;
        end else if (v < lo) begin
            v = lo;
        end
        if (relu_en && (v < 0)) begin
            v = '0;
        end
        return 64'(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwconv_lane.sv
`default_nettype none
// ============================================================================
//  Module      : pwconv_lane
//  Description : One output-channel lane: registered operands, accumulator and
//                saturating requantiser with optional ReLU.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwconv_lane
    import pwconv_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int FRAC    = 14,
    parameter int ACC_W   = 40,
    parameter int RELU_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_load,
    input  logic               op_first,
    input  logic [WIDTH-1:0]   ifm,
    input  logic [WIDTH-1:0]   weight,
    input  logic               out_load,
    input  logic [2*WIDTH-1:0] bias,
    output logic [WIDTH-1:0]   ofm
);
    localparam int c_prod_w = 2 * WIDTH;
    localparam int c_sum_w  = ACC_W + 1;

    logic signed [WIDTH-1:0]    r_ifm;
    logic signed [WIDTH-1:0]    r_wgt;
    logic                       r_first;
    logic                       r_op_valid;
    logic signed [ACC_W-1:0]    r_acc;
    logic [WIDTH-1:0]           r_ofm;
    logic signed [c_prod_w-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic signed [c_sum_w-1:0]  w_sum;

    assign w_prod = c_prod_w'(r_ifm) * c_prod_w'(r_wgt);

    always_comb begin
        w_acc_next = r_acc;
        if (r_op_valid) begin
            w_acc_next = r_first ? ACC_W'(w_prod) : r_acc + ACC_W'(w_prod);
        end
    end

    // Requantise straight from the accumulator's next value so the result
    // registers on the same edge as the final MAC.
    assign w_sum = c_sum_w'(w_acc_next) + c_sum_w'($signed(bias));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ifm      <= '0;
            r_wgt      <= '0;
            r_first    <= 1'b0;
            r_op_valid <= 1'b0;
            r_acc      <= '0;
            r_ofm      <= '0;
        end else begin
            r_op_valid <= op_load;
            if (op_load) begin
                r_ifm   <= $signed(ifm);
                r_wgt   <= $signed(weight);
                r_first <= op_first;
            end
            r_acc <= w_acc_next;
            if (out_load) begin
                r_ofm <= WIDTH'(sat_shift(128'(w_sum), FRAC, WIDTH, RELU_EN != 0));
            end
        end
    end

    assign ofm = r_ofm;

endmodule
`default_nettype wire

// File: rtl/pointwise_conv_engine.sv
`default_nettype none
// ============================================================================
//  Module      : pointwise_conv_engine
//  Description : Parametrised 1x1 convolution engine; channel-serial input,
//                DSP_NO output channels per group, valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module pointwise_conv_engine
    import pwconv_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int FRAC    = 14,
    parameter int DSP_NO  = 32,
    parameter int CHIN    = 256,
    parameter int CHOUT   = 64,
    parameter int NPIX    = 1024,
    parameter int ACC_W   = 2 * WIDTH + $clog2(CHIN),
    parameter int RELU_EN = 1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [WIDTH-1:0]                           ifm,
    input  logic                                       ifm_valid,
    output logic                                       ifm_ready,
    output logic [width_of(CHOUT/DSP_NO*CHIN)-1:0]     weight_addr,
    input  logic [DSP_NO-1:0][WIDTH-1:0]               weight_data,
    output logic [width_of(CHOUT/DSP_NO)-1:0]          bias_grp,
    input  logic [DSP_NO-1:0][2*WIDTH-1:0]             bias_data,
    output logic [DSP_NO-1:0][WIDTH-1:0]               ofm,
    output logic                                       ofm_valid,
    input  logic                                       ofm_ready,
    output logic [width_of(CHOUT/DSP_NO)-1:0]          ofm_grp,
    output logic [width_of(NPIX)-1:0]                  ofm_pix,
    output logic                                       busy,
    output logic                                       done
);
    localparam int c_groups = CHOUT / DSP_NO;
    localparam int c_ch_w   = width_of(CHIN);
    localparam int c_grp_w  = width_of(c_groups);
    localparam int c_pix_w  = width_of(NPIX);
    localparam int c_wa_w   = width_of(c_groups * CHIN);

    localparam logic [c_ch_w-1:0]  c_ch_last  = c_ch_w'(CHIN - 1);
    localparam logic [c_grp_w-1:0] c_grp_last = c_grp_w'(c_groups - 1);
    localparam logic [c_pix_w-1:0] c_pix_last = c_pix_w'(NPIX - 1);

    state_t               r_state;
    logic [c_ch_w-1:0]    r_ch;
    logic [c_grp_w-1:0]   r_grp;
    logic [c_pix_w-1:0]   r_pix;
    logic                 r_ifm_ready;
    logic                 r_ofm_valid;
    logic                 r_busy;
    logic                 r_done;
    logic [c_grp_w-1:0]   r_ofm_grp;
    logic [c_pix_w-1:0]   r_ofm_pix;

    logic w_ifm_hs;
    logic w_first;
    logic w_flush;
    logic w_last_out;

    assign w_ifm_hs   = ifm_valid & r_ifm_ready;
    assign w_first    = (r_ch == '0);
    assign w_flush    = (r_state == FLUSH);
    assign w_last_out = (r_grp == c_grp_last) && (r_pix == c_pix_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_ch        <= '0;
            r_grp       <= '0;
            r_pix       <= '0;
            r_ifm_ready <= 1'b0;
            r_ofm_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ofm_grp   <= '0;
            r_ofm_pix   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= ACC;
                        r_busy      <= 1'b1;
                        r_ifm_ready <= 1'b1;
                        r_ch        <= '0;
                        r_grp       <= '0;
                        r_pix       <= '0;
                    end
                end
                ACC: begin
                    if (w_ifm_hs) begin
                        if (r_ch == c_ch_last) begin
                            r_ch        <= '0;
                            r_ifm_ready <= 1'b0;
                            r_state     <= FLUSH;
                        end else begin
                            r_ch <= r_ch + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    r_state     <= OUT;
                    r_ofm_valid <= 1'b1;
                    r_ofm_grp   <= r_grp;
                    r_ofm_pix   <= r_pix;
                end
                OUT: begin
                    if (ofm_ready) begin
                        r_ofm_valid <= 1'b0;
                        if (w_last_out) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_grp   <= '0;
                            r_pix   <= '0;
                        end else begin
                            r_state     <= ACC;
                            r_ifm_ready <= 1'b1;
                            if (r_grp == c_grp_last) begin
                                r_grp <= '0;
                                r_pix <= r_pix + 1'b1;
                            end else begin
                                r_grp <= r_grp + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign weight_addr = c_wa_w'(int'(r_grp) * CHIN + int'(r_ch));
    assign bias_grp    = r_grp;
    assign ifm_ready   = r_ifm_ready;
    assign ofm_valid   = r_ofm_valid;
    assign ofm_grp     = r_ofm_grp;
    assign ofm_pix     = r_ofm_pix;
    assign busy        = r_busy;
    assign done        = r_done;

    for (genvar l = 0; l < DSP_NO; l++) begin : g_lane
        pwconv_lane #(
            .WIDTH   (WIDTH),
            .FRAC    (FRAC),
            .ACC_W   (ACC_W),
            .RELU_EN (RELU_EN)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .op_load  (w_ifm_hs),
            .op_first (w_first),
            .ifm      (ifm),
            .weight   (weight_data[l]),
            .out_load (w_flush),
            .bias     (bias_data[l]),
            .ofm      (ofm[l])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_pointwise_conv_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pointwise_conv_engine
//  Description : Scoreboard bench for pointwise_conv_engine (linear and ReLU
//                instances sharing one stimulus stream).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pointwise_conv_engine;
    localparam int WIDTH  = 16;
    localparam int FRAC   = 14;
    localparam int DSP_NO = 4;
    localparam int CHIN   = 4;
    localparam int CHOUT  = 8;
    localparam int NPIX   = 2;
    localparam int GROUPS = CHOUT / DSP_NO;

    typedef struct {
        logic [DSP_NO-1:0][WIDTH-1:0] lin;
        logic [DSP_NO-1:0][WIDTH-1:0] relu;
        int grp;
        int pix;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [WIDTH-1:0] ifm = '0;
    logic ifm_valid = 1'b0;
    logic ofm_ready = 1'b0;
    logic ifm_ready, ofm_valid, busy, done;
    logic [2:0] weight_addr;
    logic [0:0] bias_grp, ofm_grp;
    logic [0:0] ofm_pix;
    logic [DSP_NO-1:0][WIDTH-1:0] weight_data;
    logic [DSP_NO-1:0][2*WIDTH-1:0] bias_data;
    logic [DSP_NO-1:0][WIDTH-1:0] ofm;
    logic ifm_ready_r, ofm_valid_r, busy_r, done_r;
    logic [2:0] weight_addr_r;
    logic [0:0] bias_grp_r, ofm_grp_r;
    logic [0:0] ofm_pix_r;
    logic [DSP_NO-1:0][WIDTH-1:0] ofm_r;

    logic signed [WIDTH-1:0]   w_rom [GROUPS*CHIN][DSP_NO];
    logic signed [2*WIDTH-1:0] b_tab [GROUPS][DSP_NO];
    logic signed [WIDTH-1:0]   px    [NPIX][CHIN];

    exp_t sb[$];
    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_hs_cyc = 0;
    int ready_mode = 0;
    int stall_left = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        weight_data = '0;
        bias_data   = '0;
        for (int l = 0; l < DSP_NO; l++) begin
            weight_data[l] = w_rom[weight_addr][l];
            bias_data[l]   = b_tab[bias_grp][l];
        end
    end

    pointwise_conv_engine #(
        .WIDTH(WIDTH), .FRAC(FRAC), .DSP_NO(DSP_NO), .CHIN(CHIN),
        .CHOUT(CHOUT), .NPIX(NPIX), .RELU_EN(0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ifm(ifm), .ifm_valid(ifm_valid),
        .ifm_ready(ifm_ready), .weight_addr(weight_addr), .weight_data(weight_data),
        .bias_grp(bias_grp), .bias_data(bias_data), .ofm(ofm), .ofm_valid(ofm_valid),
        .ofm_ready(ofm_ready), .ofm_grp(ofm_grp), .ofm_pix(ofm_pix), .busy(busy), .done(done)
    );

    pointwise_conv_engine #(
        .WIDTH(WIDTH), .FRAC(FRAC), .DSP_NO(DSP_NO), .CHIN(CHIN),
        .CHOUT(CHOUT), .NPIX(NPIX), .RELU_EN(1)
    ) dut_relu (
        .clk(clk), .rst(rst), .start(start), .ifm(ifm), .ifm_valid(ifm_valid),
        .ifm_ready(ifm_ready_r), .weight_addr(weight_addr_r), .weight_data(weight_data),
        .bias_grp(bias_grp_r), .bias_data(bias_data), .ofm(ofm_r), .ofm_valid(ofm_valid_r),
        .ofm_ready(ofm_ready), .ofm_grp(ofm_grp_r), .ofm_pix(ofm_pix_r), .busy(busy_r), .done(done_r)
    );

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: exact integer dot product, floor shift, clamp, optional ReLU.
    function automatic logic [WIDTH-1:0] model(input int p, input int g, input int l, input bit relu);
        longint acc;
        longint r;
        logic [63:0] rv;
        acc = 0;
        for (int c = 0; c < CHIN; c++)
            acc += longint'(px[p][c]) * longint'(w_rom[g*CHIN+c][l]);
        r = (acc + longint'(b_tab[g][l])) >>> FRAC;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        rv = r;
        return rv[WIDTH-1:0];
    endfunction

    task automatic push_expected();
        exp_t e;
        for (int p = 0; p < NPIX; p++)
            for (int g = 0; g < GROUPS; g++) begin
                for (int l = 0; l < DSP_NO; l++) begin
                    e.lin[l]  = model(p, g, l, 1'b0);
                    e.relu[l] = model(p, g, l, 1'b1);
                end
                e.grp = g;
                e.pix = p;
                sb.push_back(e);
            end
    endtask

    task automatic set_uniform(input logic [15:0] w, input logic [15:0] x, input logic [31:0] b);
        for (int a = 0; a < GROUPS*CHIN; a++)
            for (int l = 0; l < DSP_NO; l++) w_rom[a][l] = w;
        for (int g = 0; g < GROUPS; g++)
            for (int l = 0; l < DSP_NO; l++) b_tab[g][l] = b;
        for (int p = 0; p < NPIX; p++)
            for (int c = 0; c < CHIN; c++) px[p][c] = x;
    endtask

    task automatic randomize_data();
        logic [31:0] r;
        for (int p = 0; p < NPIX; p++)
            for (int c = 0; c < CHIN; c++) begin
                r = $urandom;
                px[p][c] = {{3{r[12]}}, r[12:0]};
            end
        for (int a = 0; a < GROUPS*CHIN; a++)
            for (int l = 0; l < DSP_NO; l++) begin
                r = $urandom;
                w_rom[a][l] = r[15:0];
            end
        for (int g = 0; g < GROUPS; g++)
            for (int l = 0; l < DSP_NO; l++) begin
                r = $urandom;
                b_tab[g][l] = {{4{r[27]}}, r[27:0]};
            end
    endtask

    // Upstream: re-sends each pixel's channels once per group.
    task automatic drive_layer(input bit gaps, input int abort_after, input bit poke);
        int  n;
        bit  poked;
        n = 0;
        poked = 0;
        for (int p = 0; p < NPIX; p++)
            for (int g = 0; g < GROUPS; g++)
                for (int c = 0; c < CHIN; c++) begin
                    int waitc;
                    bit got;
                    waitc = 0;
                    got = 0;
                    while (!got) begin
                        @(negedge clk);
                        ifm = px[p][c];
                        ifm_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                        start = poke && (n == 5) && !poked;
                        if (start) poked = 1;
                        if (ifm_valid && ifm_ready) begin
                            got = 1;
                            check(int'(weight_addr) == g*CHIN + c, "weight_addr", 64'(weight_addr), 64'(g*CHIN + c));
                            if (c == CHIN - 1) last_hs_cyc = cyc;
                        end
                        waitc++;
                        if (!got && waitc > 200) begin
                            check(1'b0, "ifm_ready_timeout", 64'(0), 64'(1));
                            ifm_valid = 1'b0;
                            return;
                        end
                    end
                    n++;
                    if (n == abort_after) return;
                end
        @(negedge clk);
        ifm_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check(busy == 1'b1, "busy_after_start", 64'(busy), 64'(1));
    endtask

    task automatic run_layer(input bit gaps, input int rmode, input bit poke);
        int d0;
        bit seen;
        push_expected();
        ready_mode = rmode;
        stall_left = (rmode == 2) ? 10 : 0;
        d0 = done_cnt;
        pulse_start();
        drive_layer(gaps, -1, poke);
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) seen = 1;
        end
        check(seen, "done_seen", 64'(seen), 64'(1));
        repeat (3) @(negedge clk);
        #1;
        check(done_cnt == d0 + 1, "done_pulses", 64'(done_cnt - d0), 64'(1));
        check(sb.size() == 0, "scoreboard_empty", 64'(sb.size()), 64'(0));
        check(busy == 1'b0, "busy_after_done", 64'(busy), 64'(0));
        sb.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check(ifm_ready == 0, {tag, "_ifm_ready"}, 64'(ifm_ready), 64'(0));
        check(ofm_valid == 0, {tag, "_ofm_valid"}, 64'(ofm_valid), 64'(0));
        check(busy == 0,      {tag, "_busy"},      64'(busy),      64'(0));
        check(done == 0,      {tag, "_done"},      64'(done),      64'(0));
        check(ofm == '0,      {tag, "_ofm"},       64'(ofm),       64'(0));
        check(ofm_r == '0,    {tag, "_ofm_relu"},  64'(ofm_r),     64'(0));
        check(ofm_grp == 0 && ofm_pix == 0, {tag, "_ofm_tag"}, 64'({ofm_grp, ofm_pix}), 64'(0));
    endtask

    // Monitor: drives ofm_ready and pops the scoreboard on each acceptance.
    initial begin
        exp_t e;
        logic [DSP_NO-1:0][WIDTH-1:0] held;
        bit holding;
        bit prev_valid;
        bit r;
        holding = 0;
        prev_valid = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (holding && ofm_valid) begin
                check(ofm == held, "ofm_stable", 64'(ofm), 64'(held));
                check(ifm_ready == 1'b0, "ifm_ready_in_out", 64'(ifm_ready), 64'(0));
            end
            if (ofm_valid && !prev_valid)
                check(cyc == last_hs_cyc + 2, "latency", 64'(cyc - last_hs_cyc), 64'(2));
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = ($urandom_range(0, 2) != 0);
                default: r = (stall_left == 0);
            endcase
            if (stall_left > 0 && ofm_valid) stall_left--;
            ofm_ready = r;
            if (ofm_valid && r) begin
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_ofm", 64'(ofm), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check(ofm == e.lin, "ofm_linear", 64'(ofm), 64'(e.lin));
                    check(ofm_r == e.relu, "ofm_relu", 64'(ofm_r), 64'(e.relu));
                    check(int'(ofm_grp) == e.grp && int'(ofm_pix) == e.pix, "ofm_tag",
                          64'({ofm_grp, ofm_pix}), 64'(e.grp * 2 + e.pix));
                end
                holding = 0;
            end else if (ofm_valid) begin
                holding = 1;
                held = ofm;
            end else begin
                holding = 0;
            end
            prev_valid = ofm_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_uniform(16'h0000, 16'h0000, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b1;

        // 0.5 * 1.0 * 4 = 2.0 saturates to 0x7FFF
        set_uniform(16'h4000, 16'h2000, 32'h0);
        run_layer(1'b0, 0, 1'b0);

        // 0.25 * 1.0 * 4 = 1.0; lane 2 adds 0.5 in Q28; first output stalled
        set_uniform(16'h4000, 16'h1000, 32'h0);
        b_tab[0][2] = 32'h0800_0000;
        b_tab[1][2] = 32'h0800_0000;
        run_layer(1'b0, 2, 1'b0);

        // -1.0 weights: -1.0 linear, ReLU to zero
        set_uniform(16'hC000, 16'h1000, 32'h0);
        run_layer(1'b0, 0, 1'b0);

        // large negative saturates to 0x8000
        set_uniform(16'h8000, 16'h7FFF, 32'h0);
        run_layer(1'b0, 0, 1'b0);

        // same random data gap-free and with gaps/backpressure
        randomize_data();
        run_layer(1'b0, 0, 1'b0);
        run_layer(1'b1, 1, 1'b0);

        // abort mid-accumulation, then a full layer with a stray start
        randomize_data();
        pulse_start();
        drive_layer(1'b0, 2, 1'b0);
        @(negedge clk);
        ifm_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_state("midreset");
        @(negedge clk);
        rst = 1'b1;
        run_layer(1'b0, 0, 1'b1);

        for (int k = 0; k < 3; k++) begin
            randomize_data();
            run_layer(1'b1, 1, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
